// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: select-field slices, operation codes, flag bit positions.
package alu_pipe_pkg;

  localparam int unsigned SEL_W    = 5;
  localparam int unsigned SHIFT_HI = 4;
  localparam int unsigned SHIFT_LO = 3;
  localparam int unsigned UNIT_BIT = 2;
  localparam int unsigned OP_HI    = 1;
  localparam int unsigned OP_LO    = 0;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLG_C   = 0;
  localparam int unsigned FLG_Z   = 1;
  localparam int unsigned FLG_N   = 2;
  localparam int unsigned FLG_V   = 3;

  // Second operand selection for the adder
  typedef enum logic [1:0] {
    ARITH_ZERO = 2'b00,
    ARITH_B    = 2'b01,
    ARITH_NOTB = 2'b10,
    ARITH_ONES = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    LOGIC_AND  = 2'b00,
    LOGIC_OR   = 2'b01,
    LOGIC_XOR  = 2'b10,
    LOGIC_NOTA = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10,
    SHIFT_ZERO  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/alu_arith_logic.sv
// Combinational stage-1 unit: adder with selectable second operand, or bitwise logic.
// Carry/overflow outputs exist only when ALU_PIPE_FLAGS_EN is defined.
module alu_arith_logic
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             unit_i,
  input  logic [1:0]       op_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y1_c_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic             c_c_o,
  output logic             v_c_o
`endif
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] bop;
`ifdef ALU_PIPE_FLAGS_EN
  logic [SUM_W-1:0] sum;
`endif

  // Arithmetic (A + Bop + Cin) or logic result, selected by the unit bit
  always_comb begin
    bop    = '0;
    y1_c_o = '0;
`ifdef ALU_PIPE_FLAGS_EN
    sum    = '0;
    c_c_o  = 1'b0;
    v_c_o  = 1'b0;
`endif
    if (!unit_i) begin
      case (arith_op_e'(op_i))
        ARITH_ZERO: bop = '0;
        ARITH_B:    bop = b_i;
        ARITH_NOTB: bop = ~b_i;
        ARITH_ONES: bop = '1;
        default:    bop = '0;
      endcase
`ifdef ALU_PIPE_FLAGS_EN
      sum    = {1'b0, a_i} + {1'b0, bop} + SUM_W'(carry_i);
      y1_c_o = sum[WIDTH-1:0];
      c_c_o  = sum[WIDTH];
      v_c_o  = (a_i[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
`else
      y1_c_o = a_i + bop + WIDTH'(carry_i);
`endif
    end else begin
      case (logic_op_e'(op_i))
        LOGIC_AND:  y1_c_o = a_i & b_i;
        LOGIC_OR:   y1_c_o = a_i | b_i;
        LOGIC_XOR:  y1_c_o = a_i ^ b_i;
        LOGIC_NOTA: y1_c_o = ~a_i;
        default:    y1_c_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and tag passthrough.
// Stage 1 registers the arithmetic/logic result; stage 2 registers the shifted result and flags.
// Define ALU_PIPE_FLAGS_EN to build the flag logic; otherwise alu_flags_out is tied to zero.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               alu_clk_in,
  input  logic               alu_rst_in,
  input  logic               alu_valid_in,
  output logic               alu_ready_out,
  input  logic [SEL_W-1:0]   alu_sel_in,
  input  logic               alu_carry_in,
  input  logic [WIDTH-1:0]   alu_a_in,
  input  logic [WIDTH-1:0]   alu_b_in,
  input  logic [TAG_W-1:0]   alu_tag_in,
  output logic               alu_valid_out,
  input  logic               alu_ready_in,
  output logic [WIDTH-1:0]   alu_y_out,
  output logic [FLAGS_W-1:0] alu_flags_out,
  output logic [TAG_W-1:0]   alu_tag_out
);

  logic [WIDTH-1:0] st1_y_c;
  logic             s2_free_c;
  logic             s2_load_c;
  logic             accept_c;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q,     s1_y_d;
  logic [1:0]       s1_shift_q, s1_shift_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q,     s2_y_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic [WIDTH-1:0] sh_y_c;

`ifdef ALU_PIPE_FLAGS_EN
  logic               st1_c_c, st1_v_c;
  logic               s1_c_q, s1_c_d, s1_v_q, s1_v_d;
  logic               sh_c_c, sh_v_c;
  logic [FLAGS_W-1:0] s2_flags_q, s2_flags_d;
`endif

  alu_arith_logic #(.WIDTH(WIDTH)) u_stage1 (
    .unit_i  (alu_sel_in[UNIT_BIT]),
    .op_i    (alu_sel_in[OP_HI:OP_LO]),
    .carry_i (alu_carry_in),
    .a_i     (alu_a_in),
    .b_i     (alu_b_in),
    .y1_c_o  (st1_y_c)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .c_c_o   (st1_c_c),
    .v_c_o   (st1_v_c)
`endif
  );

  // Handshake: stage 2 can take data when empty or draining; stage 1 when empty or advancing
  assign s2_free_c     = !s2_valid_q || alu_ready_in;
  assign s2_load_c     = s1_valid_q && s2_free_c;
  assign alu_ready_out = !alu_rst_in && (!s1_valid_q || s2_free_c);
  assign accept_c      = alu_valid_in && alu_ready_out;

  // Stage-1 next state: load on accept, otherwise empty out when advanced
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_shift_d = s1_shift_q;
    s1_tag_d   = s1_tag_q;
`ifdef ALU_PIPE_FLAGS_EN
    s1_c_d     = s1_c_q;
    s1_v_d     = s1_v_q;
`endif
    if (s2_load_c) s1_valid_d = 1'b0;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_y_d     = st1_y_c;
      s1_shift_d = alu_sel_in[SHIFT_HI:SHIFT_LO];
      s1_tag_d   = alu_tag_in;
`ifdef ALU_PIPE_FLAGS_EN
      s1_c_d     = st1_c_c;
      s1_v_d     = st1_v_c;
`endif
    end
  end

  // Shifter on the stage-1 result; shifted-out bit becomes the carry
  always_comb begin
    sh_y_c = s1_y_q;
`ifdef ALU_PIPE_FLAGS_EN
    sh_c_c = s1_c_q;
    sh_v_c = s1_v_q;
`endif
    case (shift_op_e'(s1_shift_q))
      SHIFT_LEFT: begin
        sh_y_c = {s1_y_q[WIDTH-2:0], 1'b0};
`ifdef ALU_PIPE_FLAGS_EN
        sh_c_c = s1_y_q[WIDTH-1];
        sh_v_c = 1'b0;
`endif
      end
      SHIFT_RIGHT: begin
        sh_y_c = {1'b0, s1_y_q[WIDTH-1:1]};
`ifdef ALU_PIPE_FLAGS_EN
        sh_c_c = s1_y_q[0];
        sh_v_c = 1'b0;
`endif
      end
      SHIFT_ZERO: begin
        sh_y_c = '0;
`ifdef ALU_PIPE_FLAGS_EN
        sh_c_c = 1'b0;
        sh_v_c = 1'b0;
`endif
      end
      default: sh_y_c = s1_y_q;
    endcase
  end

  // Stage-2 next state: data loads only on a stage-2 load, valid follows stage 1 when free
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_tag_d   = s2_tag_q;
    if (s2_free_c) s2_valid_d = s1_valid_q;
    if (s2_load_c) begin
      s2_y_d   = sh_y_c;
      s2_tag_d = s1_tag_q;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Status flags from the final result
  always_comb begin
    s2_flags_d = s2_flags_q;
    if (s2_load_c) begin
      s2_flags_d[FLG_V] = sh_v_c;
      s2_flags_d[FLG_N] = sh_y_c[WIDTH-1];
      s2_flags_d[FLG_Z] = (sh_y_c == '0);
      s2_flags_d[FLG_C] = sh_c_c;
    end
  end

  // Flag pipeline registers
  always_ff @(posedge alu_clk_in) begin
    if (alu_rst_in) begin
      s1_c_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_flags_q <= '0;
    end else begin
      s1_c_q     <= s1_c_d;
      s1_v_q     <= s1_v_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign alu_flags_out = s2_flags_q;
`else
  assign alu_flags_out = '0;
`endif

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge alu_clk_in) begin
    if (alu_rst_in) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_shift_q <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_shift_q <= s1_shift_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign alu_valid_out = s2_valid_q;
  assign alu_y_out     = s2_y_q;
  assign alu_tag_out   = s2_tag_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the combinational 8-bit ALU, with the same 5-bit select encoding and carry-in semantics.
- Stage 1 performs the arithmetic or logic operation. Stage 2 applies the shift operation and computes the status flags.
- A valid/ready handshake on both sides supports backpressure, and a tag travels with each transaction.
- It sits between the operand-fetch logic and the result writeback of the datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width (≥2)
- TAG_W, 4, width of the transaction tag carried alongside the data

Ports:
- alu_clk_in  input  1  clock; all state updates on the rising edge
- alu_rst_in  input  1  synchronous, active-high reset
- alu_valid_in  input  1  input transaction valid
- alu_ready_out  output  1  block can accept an input this cycle
- alu_sel_in  input  5  operation select S4..S0
- alu_carry_in  input  1  carry-in (Cin)
- alu_a_in  input  WIDTH  operand A
- alu_b_in  input  WIDTH  operand B
- alu_tag_in  input  TAG_W  transaction tag
- alu_valid_out  output  1  result valid
- alu_ready_in  input  1  downstream accepts the result
- alu_y_out  output  WIDTH  result Y
- alu_flags_out  output  4  {V,N,Z,C}
- alu_tag_out  output  TAG_W  tag of the result

## Operation
Stage 1, sel[2]=0 (arithmetic):
- Compute Y1 = A + Bop + Cin in WIDTH+1 bits. C is bit WIDTH of the sum.
- Bop depends on sel[1:0]: 00 gives 0, 01 gives B, 10 gives ~B, 11 gives all-ones.
- This covers transfer, increment, add, add-with-carry, A+~B, subtract, decrement, and transfer (A + ones + 1).
- V is the signed overflow of A + Bop + Cin.

Stage 1, sel[2]=1 (logic):
- sel[1:0]: 00 gives A&B, 01 gives A|B, 10 gives A^B, 11 gives ~A.
- Cin is ignored. C=0 and V=0.

Stage 2, shift on sel[4:3]:
- 00: Y=Y1. C and V pass through.
- 01: Y=Y1<<1. C=Y1[WIDTH-1], V=0.
- 10: Y=Y1>>1 (logical). C=Y1[0], V=0.
- 11: Y=0. C=0, V=0.

Final flags: Z=(Y==0) and N=Y[WIDTH-1], both taken from the final Y.

The tag is carried unmodified alongside its operands.

## Timing
- Input accept: alu_valid_in & alu_ready_out at a rising edge.
- Latency: exactly 2 cycles from accept to alu_valid_out, when unstalled. Throughput is 1 per cycle.
- Stage advance: each stage register loads when its downstream slot is empty or is being drained in the same cycle.
- Ready: alu_ready_out = !s1_valid | (!s2_valid | alu_ready_in). It is combinational and carries no bubble.
- Stall hold: while alu_valid_out=1 & alu_ready_in=0, alu_y_out, alu_flags_out and alu_tag_out hold stable. No transaction is lost or duplicated.
- Simultaneous drain and accept: accept and output in the same cycle are both honoured. The pipeline stays full.
- Output registers update only when a stage-2 load occurs. When idle, they retain their last value.
- Reset values: alu_valid_out=0, alu_y_out=0, alu_flags_out=0, alu_tag_out=0, internal valids=0. alu_ready_out=0 while alu_rst_in=1, and 1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded at that edge. No output appears for them.

## Configuration
- ALU_PIPE_FLAGS_EN defined: flags are computed and registered as specified above.
- ALU_PIPE_FLAGS_EN undefined: the flag logic and registers are removed, and alu_flags_out is driven constant 4'b0. Y and handshake behaviour are identical in both builds.

## Structure
- Package alu_pipe_pkg holds:
  - localparams for the sel field slices (SHIFT=[4:3], UNIT=[2], OP=[1:0])
  - enums for the arithmetic, logic and shift operation codes
  - flag bit indices FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3
- Sub-module alu_arith_logic is the combinational stage-1 unit, parametrised by WIDTH. It outputs Y1, C and V.
- The top level owns the two pipeline register stages, the handshake and the shifter.

## Test plan
All scenarios use WIDTH=8, A=8'hA5, B=8'h3C.

- Subtract, sel=00010, Cin=1 → Y=8'h69, {V,N,Z,C}=1001, 2 cycles after accept.
- Decrement, A=8'h00, sel=00011, Cin=0 → Y=8'hFF, flags=0100.
- Logic ops, sel=00100/00101/00110/00111 back-to-back → Y=24, BD, 99, 5A on four consecutive cycles with tags 0..3 in order.
- Shifts, sel=01000 → Y=4A, C=1. sel=10000 → Y=52, C=1. sel=11000 → Y=00, Z=1.
- Backpressure: issue 4 transactions with alu_ready_in=0 → alu_ready_out drops after 2 accepts and the output holds the first result. Releasing ready → all 4 emerge in order with no loss or duplication.
- Reset mid-operation: assert alu_rst_in for one cycle with 2 transactions in flight → alu_valid_out=0 at the following edge and neither result appears. The next accept → result 2 cycles later.
